// File: rtl/symbol_issuer_level2_pkg.sv
// Shared types for the level-2 symbol issuer: FSM state encoding, LFSR taps,
// the symbol encoding function and a saturating counter helper.
package issuer_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ISSUE       = 3'd1,
        SHOW        = 3'd2,
        WAIT_PLAYER = 3'd3,
        JUDGE       = 3'd4,
        DONE        = 3'd5
    } issuer_state_t;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [3:0] encode_sym(input logic [3:0] sym, input logic [3:0] key);
        return {sym[2:0], sym[3]} ^ key;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/lfsr8_gen.sv
// Free-running 8-bit Galois LFSR, loaded with the seed on reset.
// Latency: one step per clock; no backpressure, never stalls.
module lfsr8_gen
    import issuer_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] state
);

    logic [7:0] r_state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= seed;
        end else begin
            r_state <= {1'b0, r_state[7:1]} ^ (r_state[0] ? LFSR_TAPS : 8'h00);
        end
    end

    assign state = r_state;

endmodule

// File: rtl/symbol_issuer_level2.sv
// Level-2 challenge issuer: shows a pseudo-random symbol, awaits Player_Ld, judges scorer result.
// Latency: 1 ISSUE + SHOW_CYCLES shown, JUDGE_DLY to verdict; no backpressure, Player_Ld is a level.
// ISSUER_NO_REPEAT_EN: a fresh issue bumps the candidate by one if it equals the previous symbol.
module symbol_issuer_level2
    import issuer_pkg::*;
#(
    parameter logic [7:0]  SEED           = 8'hA5,
    parameter logic [3:0]  KEY            = 4'hA,
    parameter logic [15:0] SHOW_CYCLES    = 16'd50,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
    parameter logic [1:0]  JUDGE_DLY      = 2'd3,
    parameter logic [3:0]  ROUNDS         = 4'd9,
    parameter logic [2:0]  MAX_MISS       = 3'd3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       start,
    input  logic       Player_Ld,
    input  logic       ledg_in,
    input  logic       ledr_in,
    output logic [3:0] RNG_op,
    output logic [3:0] Symbol,
    output logic       rng_load,
    output logic [3:0] Round,
    output logic [2:0] Miss,
    output logic       game_won,
    output logic       game_over
);

    localparam logic [15:0] SHOW_LAST  = (SHOW_CYCLES == 16'd0) ? 16'd0 : SHOW_CYCLES - 16'd1;
    localparam logic [15:0] TO_LAST    = (TIMEOUT_CYCLES == 16'd0) ? 16'd0 : TIMEOUT_CYCLES - 16'd1;
    localparam logic [15:0] JUDGE_LAST = (JUDGE_DLY == 2'd0) ? 16'd0 : {14'd0, JUDGE_DLY} - 16'd1;

    issuer_state_t r_state, w_state_nxt;
    logic [3:0]    r_symbol, w_symbol_nxt;
    logic [3:0]    r_rng_op, w_rng_op_nxt;
    logic          r_rng_load, w_rng_load_nxt;
    logic [3:0]    r_round, w_round_nxt;
    logic [2:0]    r_miss, w_miss_nxt;
    logic          r_won, w_won_nxt;
    logic          r_over, w_over_nxt;
    logic          r_retry, w_retry_nxt;
    logic [15:0]   r_show_cnt, w_show_cnt_nxt;
    logic [15:0]   r_to_cnt, w_to_cnt_nxt;
    logic [15:0]   r_judge_cnt, w_judge_cnt_nxt;
    logic [7:0]    w_lfsr;
    logic [3:0]    w_cand;
    logic          w_miss_evt;
    logic          w_lfsr_unused;

    lfsr8_gen u_lfsr (
        .clock (clock),
        .reset (reset),
        .seed  (SEED),
        .state (w_lfsr)
    );

    assign w_lfsr_unused = ^w_lfsr[7:4];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_symbol    <= 4'd0;
            r_rng_op    <= 4'd0;
            r_rng_load  <= 1'b0;
            r_round     <= 4'd0;
            r_miss      <= 3'd0;
            r_won       <= 1'b0;
            r_over      <= 1'b0;
            r_retry     <= 1'b0;
            r_show_cnt  <= 16'd0;
            r_to_cnt    <= 16'd0;
            r_judge_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_symbol    <= w_symbol_nxt;
            r_rng_op    <= w_rng_op_nxt;
            r_rng_load  <= w_rng_load_nxt;
            r_round     <= w_round_nxt;
            r_miss      <= w_miss_nxt;
            r_won       <= w_won_nxt;
            r_over      <= w_over_nxt;
            r_retry     <= w_retry_nxt;
            r_show_cnt  <= w_show_cnt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_judge_cnt <= w_judge_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_symbol_nxt    = r_symbol;
        w_rng_op_nxt    = r_rng_op;
        w_rng_load_nxt  = r_rng_load;
        w_round_nxt     = r_round;
        w_miss_nxt      = r_miss;
        w_won_nxt       = r_won;
        w_over_nxt      = r_over;
        w_retry_nxt     = r_retry;
        w_show_cnt_nxt  = r_show_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        w_judge_cnt_nxt = r_judge_cnt;
        w_miss_evt      = 1'b0;

        w_cand = w_lfsr[3:0];
`ifdef ISSUER_NO_REPEAT_EN
        if (w_cand == r_symbol) begin
            w_cand = w_cand + 4'd1;
        end
`endif

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_retry_nxt = 1'b0;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (!r_retry) begin
                    w_symbol_nxt = w_cand;
                    w_rng_op_nxt = encode_sym(w_cand, KEY);
                end
                w_rng_load_nxt = 1'b1;
                w_show_cnt_nxt = 16'd0;
                w_state_nxt    = SHOW;
            end
            SHOW: begin
                if (r_show_cnt >= SHOW_LAST) begin
                    w_rng_load_nxt = 1'b0;
                    w_to_cnt_nxt   = 16'd0;
                    w_state_nxt    = WAIT_PLAYER;
                end else begin
                    w_show_cnt_nxt = sat_inc16(r_show_cnt);
                end
            end
            WAIT_PLAYER: begin
                // An answer arriving on the timeout cycle still gets judged
                if (Player_Ld) begin
                    w_judge_cnt_nxt = 16'd0;
                    w_state_nxt     = JUDGE;
                end else if (r_to_cnt >= TO_LAST) begin
                    w_miss_evt = 1'b1;
                end else begin
                    w_to_cnt_nxt = sat_inc16(r_to_cnt);
                end
            end
            JUDGE: begin
                if (r_judge_cnt >= JUDGE_LAST) begin
                    if (ledg_in && !ledr_in) begin
                        w_round_nxt = r_round + 4'd1;
                        w_retry_nxt = 1'b0;
                        if (r_round + 4'd1 == ROUNDS) begin
                            w_won_nxt   = 1'b1;
                            w_state_nxt = DONE;
                        end else begin
                            w_state_nxt = ISSUE;
                        end
                    end else begin
                        w_miss_evt = 1'b1;
                    end
                end else begin
                    w_judge_cnt_nxt = sat_inc16(r_judge_cnt);
                end
            end
            DONE: begin
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_miss_evt) begin
            w_miss_nxt = r_miss + 3'd1;
            if (r_miss + 3'd1 == MAX_MISS) begin
                w_over_nxt  = 1'b1;
                w_state_nxt = DONE;
            end else begin
                w_retry_nxt = 1'b1;
                w_state_nxt = ISSUE;
            end
        end

        // Clear wipes the game but leaves the LFSR free-running
        if (clear) begin
            w_state_nxt     = IDLE;
            w_symbol_nxt    = 4'd0;
            w_rng_op_nxt    = 4'd0;
            w_rng_load_nxt  = 1'b0;
            w_round_nxt     = 4'd0;
            w_miss_nxt      = 3'd0;
            w_won_nxt       = 1'b0;
            w_over_nxt      = 1'b0;
            w_retry_nxt     = 1'b0;
            w_show_cnt_nxt  = 16'd0;
            w_to_cnt_nxt    = 16'd0;
            w_judge_cnt_nxt = 16'd0;
        end
    end

    assign RNG_op    = r_rng_op;
    assign Symbol    = r_symbol;
    assign rng_load  = r_rng_load;
    assign Round     = r_round;
    assign Miss      = r_miss;
    assign game_won  = r_won;
    assign game_over = r_over;

endmodule
